// File: rtl/regbank_sb.sv
// regbank_sb: scoreboarded register bank with bypassed reads, reserve/complete tracking and status flags
module regbank_sb #(
    parameter int WIDTH   = 16,
    parameter int NREG    = 8,
    parameter int ASEL    = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ASEL-1:0]  rsel_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rbusy_a,
    input  logic [ASEL-1:0]  rsel_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rbusy_b,
    input  logic             wen,
    input  logic [ASEL-1:0]  wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             sflag,
    input  logic             c,
    input  logic             c2,
    input  logic             rsv_valid,
    input  logic [ASEL-1:0]  rsv_sel,
    output logic             rsv_ready,
    input  logic             cmp_valid,
    input  logic [ASEL-1:0]  cmp_sel,
    input  logic [WIDTH-1:0] cmp_data,
    output logic [NREG-1:0]  busy_vec,
    output logic [3:0]       status,
    output logic [1:0]       err
);
    logic [WIDTH-1:0] regs [NREG];
    logic             w_ok, rsv_ok, cmp_ok;
    logic             z_a, z_b, z_w, z_r;

    assign z_a = (ZERO_R0 != 0) && (rsel_a == '0);
    assign z_b = (ZERO_R0 != 0) && (rsel_b == '0);
    assign z_w = (ZERO_R0 != 0) && (wsel == '0);
    assign z_r = (ZERO_R0 != 0) && (rsv_sel == '0);

    // A write to a busy register is dropped; a completion only counts against a busy register
    assign w_ok      = wen & ~busy_vec[wsel] & ~z_w;
    assign rsv_ready = ~busy_vec[rsv_sel];
    assign rsv_ok    = rsv_valid & rsv_ready & ~z_r;
    assign cmp_ok    = cmp_valid & busy_vec[cmp_sel];

    assign rdata_a = z_a ? '0 :
                     (w_ok && wsel == rsel_a) ? wdata :
                     (cmp_ok && cmp_sel == rsel_a) ? cmp_data : regs[rsel_a];
    assign rdata_b = z_b ? '0 :
                     (w_ok && wsel == rsel_b) ? wdata :
                     (cmp_ok && cmp_sel == rsel_b) ? cmp_data : regs[rsel_b];
    assign rbusy_a = busy_vec[rsel_a] & ~(cmp_valid && cmp_sel == rsel_a);
    assign rbusy_b = busy_vec[rsel_b] & ~(cmp_valid && cmp_sel == rsel_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy_vec <= '0;
            status   <= '0;
            err      <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (cmp_ok && cmp_sel == ASEL'(i)) begin
                    regs[i]     <= cmp_data;
                    busy_vec[i] <= 1'b0;
                end else if (w_ok && wsel == ASEL'(i)) begin
                    regs[i] <= wdata;
                end
                if (rsv_ok && rsv_sel == ASEL'(i)) busy_vec[i] <= 1'b1;
            end
            if (w_ok && sflag) status <= {wdata[WIDTH-1], c ^ c2, wdata == '0, c};
            err <= {cmp_valid & ~busy_vec[cmp_sel], wen & busy_vec[wsel]};
        end
    end
endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: directed scoreboard bench for regbank_sb, with a second ZERO_R0=1 instance on shared inputs
module tb_regbank_sb;
    logic        clk = 0, reset;
    logic [2:0]  rsel_a, rsel_b, wsel, rsv_sel, cmp_sel;
    logic [15:0] wdata, cmp_data, rdata_a, rdata_b, z_rdata_a, z_rdata_b;
    logic        wen, sflag, c, c2, rsv_valid, cmp_valid;
    logic        rbusy_a, rbusy_b, rsv_ready, z_rbusy_a, z_rbusy_b, z_rsv_ready;
    logic [7:0]  busy_vec, z_busy_vec;
    logic [3:0]  status, z_status;
    logic [1:0]  err, z_err;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    regbank_sb dut (
        .clk(clk), .reset(reset), .rsel_a(rsel_a), .rdata_a(rdata_a), .rbusy_a(rbusy_a),
        .rsel_b(rsel_b), .rdata_b(rdata_b), .rbusy_b(rbusy_b), .wen(wen), .wsel(wsel),
        .wdata(wdata), .sflag(sflag), .c(c), .c2(c2), .rsv_valid(rsv_valid), .rsv_sel(rsv_sel),
        .rsv_ready(rsv_ready), .cmp_valid(cmp_valid), .cmp_sel(cmp_sel), .cmp_data(cmp_data),
        .busy_vec(busy_vec), .status(status), .err(err)
    );

    regbank_sb #(.ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset), .rsel_a(rsel_a), .rdata_a(z_rdata_a), .rbusy_a(z_rbusy_a),
        .rsel_b(rsel_b), .rdata_b(z_rdata_b), .rbusy_b(z_rbusy_b), .wen(wen), .wsel(wsel),
        .wdata(wdata), .sflag(sflag), .c(c), .c2(c2), .rsv_valid(rsv_valid), .rsv_sel(rsv_sel),
        .rsv_ready(z_rsv_ready), .cmp_valid(cmp_valid), .cmp_sel(cmp_sel), .cmp_data(cmp_data),
        .busy_vec(z_busy_vec), .status(z_status), .err(z_err)
    );

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: got %h expected an entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        wen = 0; sflag = 0; rsv_valid = 0; cmp_valid = 0;
    endtask

    initial begin
        clr();
        reset = 0; rsel_a = 0; rsel_b = 7; wsel = 0; rsv_sel = 0; cmp_sel = 0;
        wdata = 0; cmp_data = 0; c = 0; c2 = 0;
        repeat (2) @(posedge clk);
        #2;
        push("rst_busy", 0); chk(busy_vec);
        push("rst_status", 0); chk(status);
        push("rst_err", 0); chk(err);
        push("rst_rd_a", 0); chk(rdata_a);
        push("rst_rd_b", 0); chk(rdata_b);
        reset = 1;
        step();
        // direct write with same-cycle bypass
        wen = 1; wsel = 3; wdata = 16'hA5A5; rsel_a = 3;
        push("wr_bypass", 16'hA5A5); #1 chk(rdata_a);
        step(); clr(); rsel_b = 3;
        push("wr_hold_a", 16'hA5A5); push("wr_hold_b", 16'hA5A5);
        #1 chk(rdata_a); chk(rdata_b);
        // reservation
        rsv_valid = 1; rsv_sel = 5; rsel_a = 5;
        push("rsv_ready_idle", 1); #1 chk(rsv_ready);
        step(); clr();
        push("rsv_busy", 8'h20); push("rsv_rbusy", 1); push("rsv_ready_busy", 0);
        #1 chk(busy_vec); chk(rbusy_a); chk(rsv_ready);
        // write to busy register
        wen = 1; wsel = 5; wdata = 16'hFFFF;
        push("wbusy_rd", 0); #1 chk(rdata_a);
        step(); clr();
        push("wbusy_err", 2'b01); push("wbusy_unch", 0);
        #1 chk(err); chk(rdata_a);
        step();
        push("wbusy_err_end", 0); #1 chk(err);
        // completion
        cmp_valid = 1; cmp_sel = 5; cmp_data = 16'h1234;
        push("cmp_rbusy", 0); push("cmp_bypass", 16'h1234); push("cmp_busy_still", 8'h20);
        #1 chk(rbusy_a); chk(rdata_a); chk(busy_vec);
        step(); clr();
        push("cmp_busy_clr", 0); push("cmp_stored", 16'h1234); push("cmp_err", 0);
        #1 chk(busy_vec); chk(rdata_a); chk(err);
        // spurious completion
        cmp_valid = 1; cmp_sel = 2; cmp_data = 16'hBEEF; rsel_b = 2;
        push("spur_rd", 0); #1 chk(rdata_b);
        step(); clr();
        push("spur_err", 2'b10); push("spur_unch", 0);
        #1 chk(err); chk(rdata_b);
        step();
        push("spur_err_end", 0); #1 chk(err);
        // completion and write to same busy register
        rsv_valid = 1; rsv_sel = 4;
        step(); clr();
        cmp_valid = 1; cmp_sel = 4; cmp_data = 16'h0BEE; wen = 1; wsel = 4; wdata = 16'hDEAD; rsel_a = 4;
        push("cw_bypass", 16'h0BEE); #1 chk(rdata_a);
        step(); clr();
        push("cw_err", 2'b01); push("cw_stored", 16'h0BEE); push("cw_busy", 0);
        #1 chk(err); chk(rdata_a); chk(busy_vec);
        // write, reserve, complete on different registers
        rsv_valid = 1; rsv_sel = 7;
        step(); clr();
        wen = 1; wsel = 1; wdata = 16'h0111; rsv_valid = 1; rsv_sel = 2;
        cmp_valid = 1; cmp_sel = 7; cmp_data = 16'h0777; rsel_a = 1; rsel_b = 7;
        push("multi_rd_a", 16'h0111); push("multi_rd_b", 16'h0777); push("multi_ready", 1);
        #1 chk(rdata_a); chk(rdata_b); chk(rsv_ready);
        step(); clr();
        push("multi_busy", 8'h04); push("multi_st_a", 16'h0111); push("multi_st_b", 16'h0777); push("multi_err", 0);
        #1 chk(busy_vec); chk(rdata_a); chk(rdata_b); chk(err);
        cmp_valid = 1; cmp_sel = 2; cmp_data = 16'h0222;
        step(); clr();
        // reserve and write the same idle register
        rsv_valid = 1; rsv_sel = 6; wen = 1; wsel = 6; wdata = 16'h0666; rsel_a = 6;
        step(); clr();
        push("rw_busy", 8'h40); push("rw_data", 16'h0666); push("rw_rbusy", 1);
        #1 chk(busy_vec); chk(rdata_a); chk(rbusy_a);
        // asynchronous reset mid-reservation
        reset = 0;
        push("mid_rst_busy", 0); push("mid_rst_rd", 0);
        #1 chk(busy_vec); chk(rdata_a);
        step();
        reset = 1; cmp_valid = 1; cmp_sel = 6; cmp_data = 16'h1666;
        push("old_cmp_rd", 0); #1 chk(rdata_a);
        step(); clr();
        push("old_cmp_err", 2'b10); push("old_cmp_unch", 0);
        #1 chk(err); chk(rdata_a);
        // status flags
        wen = 1; wsel = 1; wdata = 16'h0000; sflag = 1; c = 1; c2 = 0;
        step(); clr();
        push("flag_zero", 4'b0111); #1 chk(status);
        wen = 1; wsel = 2; wdata = 16'h8001; sflag = 1; c = 0; c2 = 1;
        step(); clr();
        push("flag_neg", 4'b1100); #1 chk(status);
        wen = 1; wsel = 3; wdata = 16'h0000; sflag = 0; c = 1; c2 = 0;
        step(); clr();
        push("flag_nosflag", 4'b1100); #1 chk(status);
        rsv_valid = 1; rsv_sel = 5;
        step(); clr();
        wen = 1; wsel = 5; wdata = 16'h0000; sflag = 1; c = 1; c2 = 0;
        step(); clr();
        push("flag_dropped", 4'b1100); push("flag_dropped_err", 2'b01);
        #1 chk(status); chk(err);
        cmp_valid = 1; cmp_sel = 5; cmp_data = 16'h0000;
        step(); clr();
        push("flag_cmp", 4'b1100); #1 chk(status);
        // ZERO_R0 instance
        wen = 1; wsel = 0; wdata = 16'h00FF; rsel_a = 0;
        push("z_bypass", 0); push("nz_bypass", 16'h00FF);
        #1 chk(z_rdata_a); chk(rdata_a);
        step(); clr();
        push("z_stored", 0); push("nz_stored", 16'h00FF);
        #1 chk(z_rdata_a); chk(rdata_a);
        rsv_valid = 1; rsv_sel = 0;
        push("z_rsv_ready", 1); #1 chk(z_rsv_ready);
        step(); clr();
        push("z_busy", 0); push("nz_busy", 8'h01); push("z_rbusy", 0);
        #1 chk(z_busy_vec); chk(busy_vec); chk(z_rbusy_a);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
